// File: rtl/icache_arbiter_pkg.sv
// icache_arbiter_pkg: shared widths, line type and arbiter state encoding
package icache_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int ICACHE_OFFSET = 4;
  localparam int ICACHE_PF_HOLDOFF = 2;
  typedef logic [127:0] icache_out_t;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2,
    DRAIN    = 2'd3
  } icache_arb_state_t;
endpackage

// File: rtl/icache_arbiter_if.sv
// icache_arbiter_if: fetch, prefetch and i-cache handshake bundle around the arbiter
interface icache_arbiter_if;
  import icache_arbiter_pkg::*;
  logic        flush_i;
  logic        f_req_i;
  logic [XLEN-1:0] f_addr_i;
  logic        f_done_o;
  icache_out_t f_line_o;
  logic        p_req_i;
  logic [XLEN-1:0] p_addr_i;
  logic        p_done_o;
  logic        cache_req_o;
  logic [XLEN-1:0] cache_addr_o;
  logic        cache_done_i;
  icache_out_t cache_out_i;
  logic        busy_o;
  modport master (
    input  flush_i, f_req_i, f_addr_i, p_req_i, p_addr_i, cache_done_i, cache_out_i,
    output f_done_o, f_line_o, p_done_o, cache_req_o, cache_addr_o, busy_o
  );
  modport slave (
    output flush_i, f_req_i, f_addr_i, p_req_i, p_addr_i, cache_done_i, cache_out_i,
    input  f_done_o, f_line_o, p_done_o, cache_req_o, cache_addr_o, busy_o
  );
endinterface

// File: rtl/icache_arbiter.sv
// icache_arbiter: shares the i-cache read port between demand fetches and a next-line prefetcher
module icache_arbiter
  import icache_arbiter_pkg::*;
#(
  parameter int PF_HOLDOFF = ICACHE_PF_HOLDOFF
) (
  input logic clk_i,
  input logic rst_n_i,
  icache_arbiter_if.master bus
);
  localparam int HW = PF_HOLDOFF > 0 ? $clog2(PF_HOLDOFF + 1) : 1;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DEMAND = DEMAND;
  localparam logic [1:0] S_PF = PREFETCH;
  localparam logic [1:0] S_DRAIN = DRAIN;
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic merge_q;
  logic [HW-1:0] holdoff_cnt;
  logic idle, grant_f, grant_p, line_hit, live_done;
  assign idle = state_q == S_IDLE;
  assign grant_f = idle & !bus.flush_i & bus.f_req_i;
  assign grant_p = idle & !bus.flush_i & !bus.f_req_i & bus.p_req_i & (holdoff_cnt == '0);
  assign line_hit = bus.f_addr_i[XLEN-1:ICACHE_OFFSET] == addr_q[XLEN-1:ICACHE_OFFSET];
  assign live_done = bus.cache_done_i & !bus.flush_i;
  assign bus.cache_req_o = !idle;
  assign bus.busy_o = !idle;
  assign bus.cache_addr_o = addr_q;
  assign bus.f_line_o = bus.cache_out_i;
  assign bus.f_done_o = live_done & (state_q == S_DEMAND | (state_q == S_PF & merge_q));
  assign bus.p_done_o = live_done & (state_q == S_PF);
  // next state: grants only from idle, a flush turns an in-flight read into a drain
  always_comb
    state_d = grant_f ? S_DEMAND :
              grant_p ? S_PF :
              idle ? S_IDLE :
              bus.cache_done_i ? S_IDLE :
              bus.flush_i ? S_DRAIN : state_q;
  // state, read address and merge flag for a demand riding on the current prefetch
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      merge_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= grant_f ? bus.f_addr_i : grant_p ? bus.p_addr_i : addr_q;
      merge_q <= (state_q == S_PF) & (state_d == S_PF) & (merge_q | (bus.f_req_i & line_hit));
    end
  // holdoff keeps prefetches off the port right after a demand completes or a flush
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) holdoff_cnt <= '0;
    else holdoff_cnt <= (bus.f_done_o | bus.flush_i) ? HW'(PF_HOLDOFF) :
                        (holdoff_cnt != '0) ? holdoff_cnt - HW'(1) : holdoff_cnt;
endmodule
